axis_frame_sender: RTL and testbench

//  Producer-side counterpart to the pitch detector's AXI-Stream slave input.

---
 rtl/axis_frame_sender.sv | 169 ++++++++++++++++
 tb/tb_axis_frame_sender.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_sender.sv
// Ping-pong frame buffer that replays each completed frame of strobed samples as one AXI4-Stream packet.
// Build option: define FRAME_REVERSE_EN to send each frame newest-first (tlast on index 0).
module axis_frame_sender #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic                  m00_axis_aclk,
  input  logic                  m00_axis_aresetn,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic                  sample_valid,
  output logic [DATA_WIDTH-1:0] m00_axis_tdata,
  output logic                  m00_axis_tvalid,
  output logic                  m00_axis_tlast,
  input  logic                  m00_axis_tready,
  output logic                  overrun,
  output logic [15:0]           frames_sent
);

  // state  | meaning
  // IDLE   | waiting for the oldest bank (rd_bank) to become FULL
  // PRIME  | first word of the frame is being read from the RAM
  // STREAM | beats presented on the AXIS port; next word prefetched

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM} state_t;
  typedef enum logic [1:0] {BANK_EMPTY, BANK_FULL, BANK_SENDING} bank_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  state_t                state, state_next;
  bank_t                 bank_state [2];
  logic [DATA_WIDTH-1:0] mem [2*FRAME_LEN];
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  wr_bank;
  logic [ADDR_W-1:0]     wr_idx;
  logic                  wr_accept, wr_done;

  logic                  rd_bank;
  logic [ADDR_W-1:0]     rd_idx;
  logic [ADDR_W-1:0]     rd_pos, rd_word;
  logic                  handshake, claim, release_bank;

  assign handshake = m00_axis_tvalid && m00_axis_tready;
  assign wr_accept = sample_valid && (bank_state[wr_bank] == BANK_EMPTY);
  assign wr_done   = wr_accept && (wr_idx == LAST_IDX);

  // Write side
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= sample_valid && !wr_accept;
      if (wr_accept) begin
        if (wr_idx == LAST_IDX) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + ADDR_W'(1);
        end
      end
    end
  end

  // Frame RAM: one write port, one synchronous read port
  always_ff @(posedge m00_axis_aclk) begin
    if (wr_accept)
      mem[{wr_bank, wr_idx}] <= sample_data;
    rd_data <= mem[{rd_bank, rd_word}];
  end

  // Claim, release and completion always target different banks, so they never collide
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      bank_state[0] <= BANK_EMPTY;
      bank_state[1] <= BANK_EMPTY;
    end else begin
      if (claim)
        bank_state[rd_bank] <= BANK_SENDING;
      if (release_bank)
        bank_state[rd_bank] <= BANK_EMPTY;
      if (wr_done)
        bank_state[wr_bank] <= BANK_FULL;
    end
  end

  // Read FSM: state register
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // Read FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (bank_state[rd_bank] == BANK_FULL) state_next = S_PRIME;
      S_PRIME:  state_next = S_STREAM;
      S_STREAM: if (handshake && m00_axis_tlast) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Read FSM: control outputs; rd_pos is the send-order position read from RAM at the next edge
  always_comb begin
    claim        = 1'b0;
    release_bank = 1'b0;
    rd_pos       = '0;
    case (state)
      S_IDLE:   claim = (bank_state[rd_bank] == BANK_FULL);
      S_PRIME:  rd_pos = ADDR_W'(1);
      S_STREAM: begin
        release_bank = handshake && m00_axis_tlast;
        rd_pos       = handshake ? rd_idx + ADDR_W'(2) : rd_idx + ADDR_W'(1);
      end
      default:  rd_pos = '0;
    endcase
  end

`ifdef FRAME_REVERSE_EN
  assign rd_word = ~rd_pos;
`else
  assign rd_word = rd_pos;
`endif

  // AXIS output registers
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      m00_axis_tdata  <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      rd_idx          <= '0;
      rd_bank         <= 1'b0;
      frames_sent     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (claim)
            rd_idx <= '0;
        end
        S_PRIME: begin
          m00_axis_tdata  <= rd_data;
          m00_axis_tvalid <= 1'b1;
          m00_axis_tlast  <= 1'b0;
        end
        S_STREAM: begin
          if (handshake) begin
            if (m00_axis_tlast) begin
              m00_axis_tvalid <= 1'b0;
              m00_axis_tlast  <= 1'b0;
              frames_sent     <= frames_sent + 16'd1;
              rd_bank         <= ~rd_bank;
            end else begin
              m00_axis_tdata <= rd_data;
              m00_axis_tlast <= ((rd_idx + ADDR_W'(1)) == LAST_IDX);
              rd_idx         <= rd_idx + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_sender.sv
// Testbench for axis_frame_sender (FRAME_LEN=16) with a frame-queue reference model.
module tb_axis_frame_sender;
  localparam int DW = 32;
  localparam int FL = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] sample_data;
  logic          sample_valid;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, tready, overrun;
  logic [15:0]   frames_sent;

  always #5 clk = ~clk;

  axis_frame_sender #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .ADDR_W(AW)) dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .sample_data      (sample_data),
    .sample_valid     (sample_valid),
    .m00_axis_tdata   (tdata),
    .m00_axis_tvalid  (tvalid),
    .m00_axis_tlast   (tlast),
    .m00_axis_tready  (tready),
    .overrun          (overrun),
    .frames_sent      (frames_sent)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: completed frames queued in send order, plus buffer occupancy
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cur_frame[$];
  int            occ;
  int            beat;
  int            frames_exp;
  int            ov_seen;
  logic          exp_ov;
  logic          hold;
  logic          held_last;
  logic [DW-1:0] held_data;
  logic          last_rel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    cur_frame.delete();
    occ = 0; beat = 0; frames_exp = 0;
    exp_ov = 1'b0; hold = 1'b0; last_rel = 1'b0;
  endtask

  // Runs at the negedge: checks the DUT, then predicts the effect of the coming posedge
  task automatic monitor();
    logic rel, done;
    rel = 1'b0;
    done = 1'b0;
    check("overrun", 32'(overrun), 32'(exp_ov));
    check("frames_sent", 32'(frames_sent), 32'(frames_exp));
    if (hold) begin
      check("stall_valid", 32'(tvalid), 32'd1);
      check("stall_data", tdata, held_data);
      check("stall_last", 32'(tlast), 32'(held_last));
    end
    if (beat > 0) check("no_gap", 32'(tvalid), 32'd1);
    if (last_rel) check("idle_gap", 32'(tvalid), 32'd0);
    hold = 1'b0;
    if (overrun === 1'b1) ov_seen++;
    if (tvalid === 1'b1) begin
      if (tready) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 32'(tvalid), 32'd0);
        end else begin
          check("tdata", tdata, exp_q.pop_front());
          check("tlast", 32'(tlast), 32'(beat == FL - 1));
          if (beat == FL - 1) begin
            beat = 0;
            rel = 1'b1;
            frames_exp++;
          end else begin
            beat++;
          end
        end
      end else begin
        hold = 1'b1;
        held_data = tdata;
        held_last = tlast;
      end
    end
    exp_ov = 1'b0;
    if (sample_valid) begin
      if (occ < 2) begin
        cur_frame.push_back(sample_data);
        if (cur_frame.size() == FL) begin
`ifdef FRAME_REVERSE_EN
          for (int i = FL - 1; i >= 0; i--) exp_q.push_back(cur_frame[i]);
`else
          for (int i = 0; i < FL; i++) exp_q.push_back(cur_frame[i]);
`endif
          cur_frame.delete();
          done = 1'b1;
        end
      end else begin
        exp_ov = 1'b1;
      end
    end
    last_rel = rel;
    occ = occ - int'(rel) + int'(done);
  endtask

  task automatic step(input logic sv, input logic [DW-1:0] sd, input logic rdy);
    sample_valid = sv;
    sample_data  = sd;
    tready       = rdy;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    sample_valid = 1'b0;
    #1;
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tvalid === 1'b1) && n < bound) begin
      step(1'b0, '0, 1'b1);
      n++;
    end
    check("drain_done", 32'(n < bound), 32'd1);
  endtask

  logic [DW-1:0] first_word;
  int            ov_base;

  initial begin
    rst_n = 1'b0;
    sample_valid = 1'b0;
    sample_data = '0;
    tready = 1'b0;
    ov_seen = 0;
    model_clear();
`ifdef FRAME_REVERSE_EN
    first_word = 32'd16;
`else
    first_word = 32'd1;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("init_tvalid", 32'(tvalid), 32'd0);
    check("init_frames", 32'(frames_sent), 32'd0);
    rst_n = 1'b1;

    // One frame, back-to-back, with first-beat latency
    for (int i = 1; i <= FL; i++) step(1'b1, 32'(i), 1'b1);
    check("lat_c0", 32'(tvalid), 32'd0);
    step(1'b0, '0, 1'b1);
    check("lat_c1", 32'(tvalid), 32'd0);
    step(1'b0, '0, 1'b1);
    check("lat_c2_valid", 32'(tvalid), 32'd1);
    check("lat_c2_data", tdata, first_word);
    drain(40);
    check("t1_frames", 32'(frames_sent), 32'd1);

    // Two consecutive frames, no overrun
    ov_base = ov_seen;
    for (int i = 1; i <= 2 * FL; i++) step(1'b1, 32'(i), 1'b1);
    drain(80);
    check("t2_overrun", 32'(ov_seen - ov_base), 32'd0);
    check("t2_frames", 32'(frames_sent), 32'd3);

    // tready toggling during a packet
    for (int i = 1; i <= FL; i++) step(1'b1, 32'(i + 50), 1'b0);
    for (int k = 0; k < 40; k++) step(1'b0, '0, k[0]);
    drain(40);
    check("t3_frames", 32'(frames_sent), 32'd4);

    // Downstream stalled: both banks fill, then 8 drops
    ov_base = ov_seen;
    for (int i = 1; i <= 40; i++) step(1'b1, 32'(i), 1'b0);
    step(1'b0, '0, 1'b0);
    check("t4_overruns", 32'(ov_seen - ov_base), 32'd8);
    check("t4_stall_valid", 32'(tvalid), 32'd1);
    check("t4_stall_data", tdata, first_word);
    drain(100);
    check("t4_frames", 32'(frames_sent), 32'd6);

    // Reset mid-frame, then a clean packet
    for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b1);
    do_reset();
    for (int i = 1; i <= FL; i++) step(1'b1, 32'(i + 200), 1'b1);
    drain(40);
    check("t5a_frames", 32'(frames_sent), 32'd1);

    // Reset mid-packet, then a clean packet
    for (int i = 1; i <= FL; i++) step(1'b1, 32'(i + 300), 1'b1);
    repeat (6) step(1'b0, '0, 1'b1);
    check("t5b_midpkt", 32'(tvalid), 32'd1);
    do_reset();
    for (int i = 1; i <= FL; i++) step(1'b1, 32'(i + 400), 1'b1);
    drain(40);
    check("t5b_frames", 32'(frames_sent), 32'd1);

    // Randomized strobes and backpressure
    for (int k = 0; k < 600; k++)
      step(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0));
    drain(200);
    check("rand_frames", 32'(frames_sent), 32'(frames_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
